// File: rtl/sd_host_pkg.sv
// rtl/sd_host_pkg.sv - shared states, response types and command record for the SD host CMD path
package sd_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_POST   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_136  = 2'b01,
        RESP_48   = 2'b10,
        RESP_48B  = 2'b11
    } resp_t;

    localparam logic [5:0] CMD12_INDEX = 6'd12;

    typedef struct packed {
        logic [5:0]  index;
        logic [31:0] arg;
        resp_t       resp;
    } cmd_t;

endpackage

// File: rtl/sd_cmd_timeout.sv
// rtl/sd_cmd_timeout.sv - saturating response-timeout counter with clear, enable and terminal count
module sd_cmd_timeout #(
    parameter int TO_W           = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [TO_W-1:0] TC = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + TO_W'(1);
        end
    end

    // Greater-or-equal so a count that ran past TC while timeouts were disabled still fires.
    assign terminal = (count >= TC);

endmodule

// File: rtl/sd_cmd_sequencer.sv
// rtl/sd_cmd_sequencer.sv - CMD line sequencer: CPU/AutoCMD12 arbitration, timeout, status posting (option: SDHOST_CMD_RETRY_EN)
module sd_cmd_sequencer
    import sd_host_pkg::*;
#(
    parameter int          TO_W           = 16,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] CMD12_ARG      = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_cmd_wr,
    input  logic [5:0]  cpu_cmd_index,
    input  logic [31:0] cpu_cmd_arg,
    input  logic [1:0]  cpu_resp_type,
    input  logic        timeout_enable,
    input  logic        auto_cmd12_req,
    output logic        new_command,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_argument,
    input  logic        command_complete,
    output logic        inhibit_cmd,
    output logic        enable_response,
    input  logic        ack_response,
    output logic        enable_command_complete,
    input  logic        ack_command_complete,
    output logic        cmd_complete_status,
    output logic        cmd_timeout_status,
    output logic        auto_cmd12_done,
    output logic        cmd_dropped
);

    state_t state, next_state;
    cmd_t   pend, cur;
    logic   pend_valid;
    logic   cur_is_cmd12;
    logic   timed_out;
    logic   to_terminal;
    logic   load_auto, load_pend, set_timeout;
`ifdef SDHOST_CMD_RETRY_EN
    logic   retried;
    logic   start_retry;
`endif

    sd_cmd_timeout #(
        .TO_W           (TO_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (next_state == ST_LAUNCH),
        .enable   ((state == ST_LAUNCH) || (state == ST_WAIT)),
        .terminal (to_terminal)
    );

    always_comb begin
        next_state              = state;
        new_command             = 1'b0;
        enable_response         = 1'b0;
        enable_command_complete = 1'b0;
        auto_cmd12_done         = 1'b0;
        load_auto               = 1'b0;
        load_pend               = 1'b0;
        set_timeout             = 1'b0;
`ifdef SDHOST_CMD_RETRY_EN
        start_retry             = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (auto_cmd12_req) begin
                    load_auto  = 1'b1;
                    next_state = ST_LAUNCH;
                end else if (pend_valid) begin
                    load_pend  = 1'b1;
                    next_state = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                new_command = 1'b1;
                next_state  = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion is checked first so it beats a coincident terminal count.
                if (command_complete) begin
                    next_state = (cur.resp == RESP_NONE) ? ST_POST : ST_RESP;
                end else if (timeout_enable && to_terminal) begin
`ifdef SDHOST_CMD_RETRY_EN
                    if (!retried) begin
                        start_retry = 1'b1;
                        next_state  = ST_LAUNCH;
                    end else begin
                        set_timeout = 1'b1;
                        next_state  = ST_POST;
                    end
`else
                    set_timeout = 1'b1;
                    next_state  = ST_POST;
`endif
                end
            end
            ST_RESP: begin
                enable_response = 1'b1;
                if (ack_response) next_state = ST_POST;
            end
            ST_POST: begin
                enable_command_complete = 1'b1;
                if (ack_command_complete) begin
                    auto_cmd12_done = cur_is_cmd12;
                    next_state      = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            pend_valid   <= 1'b0;
            pend         <= '0;
            cur          <= '0;
            cur_is_cmd12 <= 1'b0;
            timed_out    <= 1'b0;
        end else begin
            state <= next_state;

            if (cpu_cmd_wr && !pend_valid) begin
                pend_valid <= 1'b1;
                pend       <= '{index: cpu_cmd_index, arg: cpu_cmd_arg,
                                resp: resp_t'(cpu_resp_type)};
            end else if (load_pend) begin
                pend_valid <= 1'b0;
            end

            if (load_auto) begin
                cur          <= '{index: CMD12_INDEX, arg: CMD12_ARG, resp: RESP_48B};
                cur_is_cmd12 <= 1'b1;
                timed_out    <= 1'b0;
            end else if (load_pend) begin
                cur          <= pend;
                cur_is_cmd12 <= 1'b0;
                timed_out    <= 1'b0;
            end else if (set_timeout) begin
                timed_out    <= 1'b1;
            end
        end
    end

`ifdef SDHOST_CMD_RETRY_EN
    always_ff @(posedge clock) begin
        if (reset || (state == ST_IDLE)) begin
            retried <= 1'b0;
        end else if (start_retry) begin
            retried <= 1'b1;
        end
    end
`endif

    assign inhibit_cmd         = (state != ST_IDLE);
    assign cmd_index           = cur.index;
    assign cmd_argument        = cur.arg;
    assign cmd_complete_status = enable_command_complete && !timed_out;
    assign cmd_timeout_status  = enable_command_complete && timed_out;
    assign cmd_dropped         = cpu_cmd_wr && pend_valid;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb/tb_sd_cmd_sequencer.sv - scoreboard bench for sd_cmd_sequencer (retry variant under SDHOST_CMD_RETRY_EN)
module tb_sd_cmd_sequencer;

    localparam logic [31:0] C12_ARG = 32'hC0DE_0012;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_cmd_wr = 1'b0;
    logic [5:0]  cpu_cmd_index = '0;
    logic [31:0] cpu_cmd_arg = '0;
    logic [1:0]  cpu_resp_type = '0;
    logic        timeout_enable = 1'b0;
    logic        auto_cmd12_req = 1'b0;
    logic        new_command;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_argument;
    logic        command_complete = 1'b0;
    logic        inhibit_cmd;
    logic        enable_response;
    logic        ack_response = 1'b0;
    logic        enable_command_complete;
    logic        ack_command_complete = 1'b0;
    logic        cmd_complete_status;
    logic        cmd_timeout_status;
    logic        auto_cmd12_done;
    logic        cmd_dropped;

    sd_cmd_sequencer #(
        .TO_W           (16),
        .TIMEOUT_CYCLES (16),
        .CMD12_ARG      (C12_ARG)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .cpu_cmd_wr              (cpu_cmd_wr),
        .cpu_cmd_index           (cpu_cmd_index),
        .cpu_cmd_arg             (cpu_cmd_arg),
        .cpu_resp_type           (cpu_resp_type),
        .timeout_enable          (timeout_enable),
        .auto_cmd12_req          (auto_cmd12_req),
        .new_command             (new_command),
        .cmd_index               (cmd_index),
        .cmd_argument            (cmd_argument),
        .command_complete        (command_complete),
        .inhibit_cmd             (inhibit_cmd),
        .enable_response         (enable_response),
        .ack_response            (ack_response),
        .enable_command_complete (enable_command_complete),
        .ack_command_complete    (ack_command_complete),
        .cmd_complete_status     (cmd_complete_status),
        .cmd_timeout_status      (cmd_timeout_status),
        .auto_cmd12_done         (auto_cmd12_done),
        .cmd_dropped             (cmd_dropped)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
    } launch_t;

    launch_t    exp_launch_q[$];
    logic [1:0] exp_post_q[$];
    int         exp_done_q[$];
    int         exp_drop_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   resp_seen = 0;
    logic hold_ack = 1'b0;
    logic prev_ecc = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clock) begin
        if (!reset) begin
            if (enable_response) resp_seen++;
            if (new_command) begin
                if (exp_launch_q.size() == 0) chk("unexpected_launch", 1, 0);
                else begin
                    launch_t e;
                    e = exp_launch_q.pop_front();
                    chk("launch_index", cmd_index, e.idx);
                    chk("launch_arg", cmd_argument, e.arg);
                    chk("launch_inhibit", inhibit_cmd, 1);
                end
            end
            if (enable_command_complete && !prev_ecc) begin
                if (exp_post_q.size() == 0) chk("unexpected_post", 1, 0);
                else chk("post_status", {cmd_complete_status, cmd_timeout_status},
                         exp_post_q.pop_front());
            end
            if (auto_cmd12_done) begin
                if (exp_done_q.size() == 0) chk("unexpected_cmd12_done", 1, 0);
                else void'(exp_done_q.pop_front());
            end
            if (cmd_dropped) begin
                if (exp_drop_q.size() == 0) chk("unexpected_drop", 1, 0);
                else void'(exp_drop_q.pop_front());
            end
        end
        prev_ecc = enable_command_complete;
    end

    initial forever begin
        @(negedge clock);
        if (enable_response && !hold_ack && !reset) begin
            @(posedge clock); #1 ack_response = 1'b1;
            @(posedge clock); #1 ack_response = 1'b0;
        end
    end

    initial forever begin
        @(negedge clock);
        if (enable_command_complete && !reset) begin
            @(posedge clock); #1 ack_command_complete = 1'b1;
            @(posedge clock); #1 ack_command_complete = 1'b0;
        end
    end

    task automatic cpu_write(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [1:0] rt, output int wr_cycle);
        @(posedge clock); #1;
        cpu_cmd_wr = 1'b1; cpu_cmd_index = idx; cpu_cmd_arg = arg; cpu_resp_type = rt;
        wr_cycle = cyc;
        @(posedge clock); #1 cpu_cmd_wr = 1'b0;
    endtask

    task automatic pulse_complete();
        @(posedge clock); #1 command_complete = 1'b1;
        @(posedge clock); #1 command_complete = 1'b0;
    endtask

    task automatic wait_launch(input string name);
        int n = 0;
        @(negedge clock);
        while (!new_command && n < 300) begin @(negedge clock); n++; end
        if (!new_command) chk({name, "_launch_wait"}, 0, 1);
    endtask

    task automatic wait_post(input string name);
        int n = 0;
        @(negedge clock);
        while (!enable_command_complete && n < 300) begin @(negedge clock); n++; end
        if (!enable_command_complete) chk({name, "_post_wait"}, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clock);
        while (inhibit_cmd && n < 300) begin @(negedge clock); n++; end
        if (inhibit_cmd) chk({name, "_idle_wait"}, 0, 1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_outs"}, {new_command, inhibit_cmd, enable_response, enable_command_complete,
                              cmd_complete_status, cmd_timeout_status, auto_cmd12_done, cmd_dropped}, 0);
        chk({name, "_index"}, cmd_index, 0);
        chk({name, "_arg"}, cmd_argument, 0);
    endtask

    initial begin
        int w, l0, l1, p, r0, n;
        launch_t e;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_all_zero("reset");
        @(posedge clock); #1 reset = 1'b0;

        // 1: basic R48 command, completion after 20 cycles
        timeout_enable = 1'b0;
        e = '{6'd17, 32'h0000_0200}; exp_launch_q.push_back(e); exp_post_q.push_back(2'b10);
        r0 = resp_seen;
        cpu_write(6'd17, 32'h0000_0200, 2'b10, w);
        wait_launch("t1");
        chk("t1_latency", cyc - w, 2);
        repeat (19) @(posedge clock);
        pulse_complete();
        wait_idle("t1");
        chk("t1_resp_seen", resp_seen > r0, 1);

        // 2: timeout after TIMEOUT_CYCLES
        timeout_enable = 1'b1;
        e = '{6'd5, 32'h0000_ABCD}; exp_launch_q.push_back(e);
`ifdef SDHOST_CMD_RETRY_EN
        exp_launch_q.push_back(e);
`endif
        exp_post_q.push_back(2'b01);
        cpu_write(6'd5, 32'h0000_ABCD, 2'b10, w);
        wait_launch("t2");
        l0 = cyc;
`ifdef SDHOST_CMD_RETRY_EN
        wait_launch("t2_retry");
        chk("t2_retry_gap", cyc - l0, 16);
        l0 = cyc;
`endif
        wait_post("t2");
        chk("t2_timeout_latency", cyc - l0, 16);
        wait_idle("t2");

        // 2b: timeouts disabled, resp none: waits indefinitely, never requests a response load
        timeout_enable = 1'b0;
        e = '{6'd6, 32'h6666_0006}; exp_launch_q.push_back(e); exp_post_q.push_back(2'b10);
        r0 = resp_seen;
        cpu_write(6'd6, 32'h6666_0006, 2'b00, w);
        wait_launch("t2b");
        repeat (2000) @(posedge clock);
        @(negedge clock);
        chk("t2b_no_post", enable_command_complete, 0);
        chk("t2b_still_inhibit", inhibit_cmd, 1);
        pulse_complete();
        wait_idle("t2b");
        chk("t2b_no_resp", resp_seen, r0);

        // 5: completion coincident with terminal count wins
        timeout_enable = 1'b1;
        e = '{6'd7, 32'h0000_0777}; exp_launch_q.push_back(e); exp_post_q.push_back(2'b10);
        cpu_write(6'd7, 32'h0000_0777, 2'b00, w);
        wait_launch("t5");
        l0 = cyc;
        repeat (15) @(posedge clock);
        #1 command_complete = 1'b1;
        @(posedge clock); #1 command_complete = 1'b0;
        wait_post("t5");
        chk("t5_post_latency", cyc - l0, 16);
        wait_idle("t5");
        timeout_enable = 1'b0;

        // 3: AutoCMD12 and CPU write in the same IDLE cycle
        e = '{6'd12, C12_ARG}; exp_launch_q.push_back(e); exp_post_q.push_back(2'b10);
        exp_done_q.push_back(1);
        e = '{6'd18, 32'h1234_5678}; exp_launch_q.push_back(e); exp_post_q.push_back(2'b10);
        @(posedge clock); #1;
        auto_cmd12_req = 1'b1;
        cpu_cmd_wr = 1'b1; cpu_cmd_index = 6'd18; cpu_cmd_arg = 32'h1234_5678; cpu_resp_type = 2'b01;
        @(posedge clock); #1 cpu_cmd_wr = 1'b0;
        wait_launch("t3_cmd12");
        pulse_complete();
        n = 0;
        @(negedge clock);
        while (!auto_cmd12_done && n < 300) begin @(negedge clock); n++; end
        chk("t3_cmd12_done_seen", auto_cmd12_done, 1);
        @(posedge clock); #1 auto_cmd12_req = 1'b0;
        wait_launch("t3_cpu");
        pulse_complete();
        wait_idle("t3");

        // 4: two writes while busy: first pends, second dropped
        e = '{6'd20, 32'h0000_0020}; exp_launch_q.push_back(e); exp_post_q.push_back(2'b10);
        cpu_write(6'd20, 32'h0000_0020, 2'b00, w);
        wait_launch("t4_a");
        e = '{6'd21, 32'h0000_0021}; exp_launch_q.push_back(e); exp_post_q.push_back(2'b10);
        cpu_write(6'd21, 32'h0000_0021, 2'b00, w);
        exp_drop_q.push_back(1);
        cpu_write(6'd22, 32'h0000_0022, 2'b00, w);
        pulse_complete();
        wait_launch("t4_b");
        pulse_complete();
        wait_idle("t4");

        // 6: reset while waiting on a withheld response ack
        hold_ack = 1'b1;
        e = '{6'd9, 32'h0909_0909}; exp_launch_q.push_back(e);
        cpu_write(6'd9, 32'h0909_0909, 2'b10, w);
        wait_launch("t6");
        pulse_complete();
        n = 0;
        @(negedge clock);
        while (!enable_response && n < 50) begin @(negedge clock); n++; end
        chk("t6_in_resp", enable_response, 1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk_all_zero("t6_reset");
        hold_ack = 1'b0;

        repeat (30) @(posedge clock);
        chk("sb_launch_empty", exp_launch_q.size(), 0);
        chk("sb_post_empty", exp_post_q.size(), 0);
        chk("sb_done_empty", exp_done_q.size(), 0);
        chk("sb_drop_empty", exp_drop_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
